instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage for the A2K multi-cycle core. Holds the program counter and fetches one 32-bit instruction at a time from instruction memory over a request/acknowledge handshake. It presents the held instruction and its opcode field to the control unit. When the downstream datapath retires the instruction, the stage computes the next PC itself from the control unit's brancheq/branchne/jump outputs and the ALU zero flag.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word; sampled only when imem_ack & imem_req.
- instr  out  32  held instruction register.
- opcode  out  6  instr[31:26]; drives the control unit.
- instr_valid  out  1  instr holds a fetched, unretired instruction.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- instr_done  in  1  downstream retires the held instruction this cycle.
- jump, brancheq, branchne  in  1 each  control unit decode of the held instruction; sampled with instr_done.
- alu_zero  in  1  ALU zero flag; sampled with instr_done.

## Operation
- FSM states: BOOT, REQ, VALID.
- Reset values: state=BOOT, pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0.
- BOOT: imem_req=0. Unconditionally moves to REQ on the next edge.
- REQ: imem_req=1, imem_addr=pc held stable.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, go to VALID.
  - Without imem_ack: stay in REQ indefinitely. There is no timeout.
- VALID: imem_req=0, instr_valid=1.
  - On instr_done: pc<=next_pc, instr_valid<=0, go to REQ. instr keeps its old value.
  - Without instr_done: hold all state.
- next_pc priority:
  1. jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. Taken branch, (brancheq & alu_zero) | (branchne & ~alu_zero): pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}, modulo 2^32.
  3. Otherwise: pc_plus4.
- If jump and a branch are both asserted, jump wins.
- If brancheq and branchne are both asserted, the taken condition is evaluated as the OR above.
- All PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 32'h0.
- Boundary conditions:
  - imem_ack outside REQ is ignored.
  - instr_done outside VALID is ignored. pc and state are unchanged.
  - Redirect inputs are don't-care unless instr_done is sampled in VALID.
- Reset mid-fetch abandons the request; the FSM restarts from BOOT. Instruction memory shares rst_n and must drop any outstanding response.

## Timing
- imem_req rises in the cycle after reset deassertion plus one (the BOOT cycle).
- Response latency: imem_ack in cycle N gives instr_valid=1 and new instr/opcode in cycle N+1.
- Zero-wait memory means imem_ack in the first REQ cycle.
- Redirect: instr_done in cycle M gives the new pc and imem_req=1 in cycle M+1.
- Best-case throughput: 2 cycles per instruction (zero-wait memory, instr_done in the first VALID cycle).
- All outputs are registered or decoded from registered state only. No input-to-output combinational path.

## Configuration
- IFETCH_PERF_EN defined: adds two outputs.
  - fetch_count [31:0] increments on each imem_ack accepted in REQ.
  - wait_count [31:0] increments on each REQ cycle without imem_ack.
  - Both reset to 0 and wrap at 2^32.
- IFETCH_PERF_EN undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Reset with RESET_PC=32'h0000_0040 → imem_req=0 in BOOT; then imem_req=1, imem_addr=32'h40; instr_valid=0 throughout reset.
- Zero-wait ack of 32'h2001_0005, instr_done next cycle with no redirect → instr_valid one cycle; opcode=6'h08; next imem_addr=32'h44.
- pc=32'h100, instr imm16=16'hFFFE, brancheq=1, alu_zero=1 at instr_done → next pc=32'h0FC. Repeat with alu_zero=0 → next pc=32'h104.
- pc=32'h1000_0008, instr[25:0]=26'h000_0010, jump=1 and branchne=1 both asserted → next pc=32'h1000_0040 (jump wins).
- Memory holds ack low 5 cycles → imem_addr stable, imem_req stays 1; spurious imem_ack and instr_done in wrong states change nothing. With IFETCH_PERF_EN, wait_count=5 and fetch_count=1.
- rst_n asserted in REQ with ack pending → outputs immediately at reset values; restart fetches RESET_PC. PC wrap case: pc=32'hFFFF_FFFC, no redirect → next pc=32'h0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage for the A2K multi-cycle core: PC register, request/ack instruction fetch, next-PC redirect.
// Optional IFETCH_PERF_EN adds fetch_count / wait_count performance counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_done,
    input  logic        jump,
    input  logic        brancheq,
    input  logic        branchne,
    input  logic        alu_zero
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] wait_count
`endif
);

    // state | meaning
    // BOOT  | first cycle after reset, no request yet
    // REQ   | request outstanding at imem_addr = pc, waiting for imem_ack
    // VALID | instr holds a fetched instruction, waiting for instr_done
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        fetch_accept;
    logic        retire;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = REQ;
            REQ:     if (imem_ack) state_nxt = VALID;
            VALID:   if (instr_done) state_nxt = REQ;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        imem_req    = (state == REQ);
        instr_valid = (state == VALID);
    end

    assign fetch_accept = (state == REQ) && imem_ack;
    assign retire       = (state == VALID) && instr_done;

    assign pc_plus4      = pc + 32'd4;
    assign imem_addr     = pc;
    assign opcode        = instr[31:26];
    assign branch_taken  = (brancheq & alu_zero) | (branchne & ~alu_zero);
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

    // Jump has priority over any branch decode.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            instr <= 32'h0;
        end else begin
            if (fetch_accept) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                pc <= next_pc;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'h0;
            wait_count  <= 32'h0;
        end else if (state == REQ) begin
            if (imem_ack) begin
                fetch_count <= fetch_count + 32'd1;
            end else begin
                wait_count <= wait_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: table vectors, long branch walk, random traffic, reset mid-fetch.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_done;
    logic        jump;
    logic        brancheq;
    logic        branchne;
    logic        alu_zero;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] wait_count;
`endif

    instruction_fetch #(.RESET_PC(32'h0000_0040)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .opcode(opcode),
        .instr_valid(instr_valid),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .instr_done(instr_done),
        .jump(jump),
        .brancheq(brancheq),
        .branchne(branchne),
        .alu_zero(alu_zero)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_count(fetch_count),
        .wait_count(wait_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_pc;
    int          model_fetches;
    int          model_waits;

    typedef struct {
        logic [31:0] word;
        int          waits;
        int          hold;
        logic        j;
        logic        beq;
        logic        bne;
        logic        z;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule, written as plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic j, input logic beq, input logic bne,
                                             input logic z);
        logic [31:0] seq;
        int          offs;
        seq = cur + 32'd4;
        offs = int'($signed(word[15:0])) * 4;
        if (j) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if ((beq && z) || (bne && !z)) return seq + 32'(offs);
        return seq;
    endfunction

    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout actual=%b required=1", imem_req);
        end
    endtask

    // One full fetch/retire transaction; spurious ack/done injected in the wrong states.
    task automatic do_instr(input logic [31:0] word, input int waits, input int hold,
                            input logic j, input logic beq, input logic bne, input logic z,
                            input logic [31:0] exp_pc);
        wait_req();
        chk("req_addr", imem_addr, model_pc);
        chk("req_pc", pc, model_pc);
        for (int w = 0; w < waits; w++) begin
            imem_ack   = 1'b0;
            instr_done = 1'($urandom);
            jump       = 1'($urandom);
            brancheq   = 1'($urandom);
            branchne   = 1'($urandom);
            alu_zero   = 1'($urandom);
            tick();
            model_waits++;
            chk("wait_req", {31'h0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, model_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        instr_done = 1'($urandom);
        tick();
        model_fetches++;
        imem_ack   = 1'b0;
        instr_done = 1'b0;
        chk("fetch_valid", {31'h0, instr_valid}, 32'h1);
        chk("fetch_req", {31'h0, imem_req}, 32'h0);
        chk("fetch_instr", instr, word);
        chk("fetch_opcode", {26'h0, opcode}, {26'h0, word[31:26]});
        chk("fetch_pc", pc, model_pc);
        chk("fetch_pc4", pc_plus4, model_pc + 32'd4);
        for (int d = 0; d < hold; d++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            tick();
            imem_ack = 1'b0;
            chk("hold_valid", {31'h0, instr_valid}, 32'h1);
            chk("hold_instr", instr, word);
            chk("hold_pc", pc, model_pc);
        end
        instr_done = 1'b1;
        jump       = j;
        brancheq   = beq;
        branchne   = bne;
        alu_zero   = z;
        tick();
        instr_done = 1'b0;
        jump       = 1'($urandom);
        brancheq   = 1'($urandom);
        branchne   = 1'($urandom);
        alu_zero   = 1'($urandom);
        model_pc   = exp_pc;
        chk("retire_pc", pc, exp_pc);
        chk("retire_req", {31'h0, imem_req}, 32'h1);
        chk("retire_valid", {31'h0, instr_valid}, 32'h0);
        chk("retire_instr", instr, word);
    endtask

    task automatic check_reset_values();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_pc", pc, 32'h40);
        chk("rst_addr", imem_addr, 32'h40);
        chk("rst_instr", instr, 32'h0);
`ifdef IFETCH_PERF_EN
        chk("rst_fetch_cnt", fetch_count, 32'h0);
        chk("rst_wait_cnt", wait_count, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] w;
        logic        rj, rbeq, rbne, rz;

        vecs[0]  = '{32'h2001_0005, 0, 0, 0, 0, 0, 0, 32'h0000_0044};
        vecs[1]  = '{32'h0800_0040, 0, 1, 1, 0, 0, 0, 32'h0000_0100};
        vecs[2]  = '{32'h1000_FFFE, 1, 0, 0, 1, 0, 1, 32'h0000_00FC};
        vecs[3]  = '{32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0000_0100};
        vecs[4]  = '{32'h1000_FFFE, 0, 0, 0, 1, 0, 0, 32'h0000_0104};
        vecs[5]  = '{32'h0000_0000, 5, 3, 0, 0, 0, 0, 32'h0000_0108};
        vecs[6]  = '{32'h1400_0004, 0, 0, 0, 0, 1, 0, 32'h0000_011C};
        vecs[7]  = '{32'h1400_FFFF, 2, 1, 0, 1, 1, 0, 32'h0000_011C};
        vecs[8]  = '{32'h1000_0002, 0, 0, 0, 1, 1, 1, 32'h0000_0128};
        vecs[9]  = '{32'h1000_FFB4, 0, 0, 0, 1, 0, 1, 32'hFFFF_FFFC};
        vecs[10] = '{32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0000_0000};
        vecs[11] = '{32'h0800_0010, 0, 0, 1, 0, 0, 0, 32'h0000_0040};

        rst_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        instr_done = 1'b0;
        jump = 1'b0;
        brancheq = 1'b0;
        branchne = 1'b0;
        alu_zero = 1'b0;
        model_pc = 32'h40;
        model_fetches = 0;
        model_waits = 0;

        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'($urandom);
            instr_done = 1'($urandom);
            tick();
            check_reset_values();
        end
        imem_ack = 1'b0;
        instr_done = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        chk("boot_req", {31'h0, imem_req}, 32'h0);
        chk("boot_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h40);

        // Zero-wait fetch followed by immediate retire: instr_valid must last one cycle.
        for (int i = 0; i < 12; i++) begin
            do_instr(vecs[i].word, vecs[i].waits, vecs[i].hold, vecs[i].j, vecs[i].beq,
                     vecs[i].bne, vecs[i].z, vecs[i].exp_pc);
        end
`ifdef IFETCH_PERF_EN
        chk("perf_fetch_tbl", fetch_count, 32'(model_fetches));
        chk("perf_wait_tbl", wait_count, 32'(model_waits));
`endif

        // Walk pc up by max forward branches until the upper nibble becomes 1.
        for (int i = 0; i < 2048; i++) begin
            do_instr(32'h1000_7FFF, 0, 0, 0, 1, 0, 1,
                     ref_next(model_pc, 32'h1000_7FFF, 0, 1, 0, 1));
        end
        chk("walk_pc", pc, 32'h1000_0040);
        do_instr(32'h0800_0002, 0, 0, 1, 0, 0, 0, 32'h1000_0008);
        do_instr(32'h0800_0010, 1, 0, 1, 0, 1, 0, 32'h1000_0040);

        for (int i = 0; i < 200; i++) begin
            w    = $urandom;
            rj   = ($urandom_range(0, 3) == 0);
            rbeq = 1'($urandom);
            rbne = 1'($urandom);
            rz   = 1'($urandom);
            do_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), rj, rbeq, rbne, rz,
                     ref_next(model_pc, w, rj, rbeq, rbne, rz));
        end
`ifdef IFETCH_PERF_EN
        chk("perf_fetch_rand", fetch_count, 32'(model_fetches));
        chk("perf_wait_rand", wait_count, 32'(model_waits));
`endif

        // Reset while a request is outstanding.
        wait_req();
        imem_ack = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        imem_ack = 1'b0;
        #1;
        check_reset_values();
        tick();
        check_reset_values();
        #2 rst_n = 1'b1;
        #1;
        chk("rerst_boot_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("rerst_req", {31'h0, imem_req}, 32'h1);
        chk("rerst_addr", imem_addr, 32'h40);
        model_pc = 32'h40;
        model_fetches = 0;
        model_waits = 0;
        do_instr(32'h2001_0005, 0, 0, 0, 0, 0, 0, 32'h0000_0044);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
